// File: rtl/alu_issue_ctrl_pkg.sv
// Shared constants for the ALU issue controller: opcodes, ALU control codes, flag bits, FSM states.
package alu_issue_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_ADDI   = 6'h01;
  localparam logic [5:0] OP_BRANCH = 6'h02;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_COMP = 4'b0001;
  localparam logic [3:0] ALU_DIFF = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam int         ALU_VAR_SHIFT_BIT = 3;

  // alu_flag layout is {carry, rs<0, rs==0}
  localparam int FLAG_ZERO  = 0;
  localparam int FLAG_NEG   = 1;
  localparam int FLAG_CARRY = 2;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE   = 2'd0;
  localparam state_t S_DECODE = 2'd1;
  localparam state_t S_EXEC   = 2'd2;
  localparam state_t S_RESP   = 2'd3;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [1:0] rsvd;
    logic [3:0] funct;
  } instr_fields_t;

  function automatic logic branch_eval(input logic [2:0] flag, input logic [1:0] sel);
    logic taken;
    case (sel)
      2'd0:    taken = flag[FLAG_ZERO];
      2'd1:    taken = flag[FLAG_NEG];
      2'd2:    taken = flag[FLAG_CARRY];
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, ALU and result signals of the issue controller; slave = controller, master = environment.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) ();
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [CTRL_W-1:0] alu_control;
  logic [4:0]        alu_shamt;
  logic              alu_use_imm;
  logic [DATA_W-1:0] imm32;
  logic [DATA_W-1:0] alu_out;
  logic [2:0]        alu_flag;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic [4:0]        res_rd;
  logic              res_we;
  logic              branch_taken;
  logic              illegal;

  modport slave (
    input  instr_valid, instr, alu_out, alu_flag, res_ready,
    output instr_ready, alu_control, alu_shamt, alu_use_imm, imm32,
           res_valid, res_data, res_rd, res_we, branch_taken, illegal
  );

  modport master (
    output instr_valid, instr, alu_out, alu_flag, res_ready,
    input  instr_ready, alu_control, alu_shamt, alu_use_imm, imm32,
           res_valid, res_data, res_rd, res_we, branch_taken, illegal
  );
endinterface

// File: rtl/alu_instr_decode.sv
// Combinational field decode and legality check of one instruction word; no state, zero latency.
module alu_instr_decode
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic [31:0]       instr,
  output logic              legal,
  output logic              is_branch,
  output logic              use_imm,
  output logic              we,
  output logic [CTRL_W-1:0] ctrl,
  output logic [4:0]        shamt,
  output logic [4:0]        rd,
  output logic [DATA_W-1:0] imm32,
  output logic [1:0]        br_sel
);
  instr_fields_t f;
  logic          unused_bits;

  assign f           = instr;
  assign unused_bits = ^{f.rs, f.rsvd};

  always_comb begin
    legal     = 1'b0;
    is_branch = 1'b0;
    use_imm   = 1'b0;
    we        = 1'b0;
    ctrl      = '0;
    shamt     = '0;
    rd        = '0;
    imm32     = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    br_sel    = f.rt[1:0];
    case (f.opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        ctrl  = CTRL_W'(f.funct);
        shamt = f.shamt;
        we    = 1'b1;
        rd    = f.rd;
      end
      OP_ADDI: begin
        legal   = 1'b1;
        ctrl    = CTRL_W'(ALU_ADD);
        use_imm = 1'b1;
        we      = 1'b1;
        rd      = f.rt;
      end
      OP_BRANCH: begin
        legal     = 1'b1;
        is_branch = 1'b1;
        ctrl      = CTRL_W'(ALU_ADD);
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to an external ALU: 3 cycles accept->result (2 if illegal), result held until res_ready.
// Optional retired-instruction counter port retired_cnt under macro ALU_PERF_CNT_EN.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_ctrl_if.slave bus
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [31:0]     retired_cnt
`endif
);
  state_t            state_q, state_d;
  logic [31:0]       instr_q, instr_d;
  logic [CTRL_W-1:0] alu_control_q, alu_control_d;
  logic [4:0]        alu_shamt_q, alu_shamt_d;
  logic              alu_use_imm_q, alu_use_imm_d;
  logic [DATA_W-1:0] imm32_q, imm32_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic [4:0]        res_rd_q, res_rd_d;
  logic              res_we_q, res_we_d;
  logic              branch_q, branch_d;
  logic              illegal_q, illegal_d;

  logic              dec_legal, dec_is_branch, dec_use_imm, dec_we;
  logic [CTRL_W-1:0] dec_ctrl;
  logic [4:0]        dec_shamt, dec_rd;
  logic [DATA_W-1:0] dec_imm32;
  logic [1:0]        dec_br_sel;
  logic              resp_hs;

  alu_instr_decode #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_decode (
    .instr     (instr_q),
    .legal     (dec_legal),
    .is_branch (dec_is_branch),
    .use_imm   (dec_use_imm),
    .we        (dec_we),
    .ctrl      (dec_ctrl),
    .shamt     (dec_shamt),
    .rd        (dec_rd),
    .imm32     (dec_imm32),
    .br_sel    (dec_br_sel)
  );

  assign resp_hs = (state_q == S_RESP) && bus.res_ready;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    alu_control_d = alu_control_q;
    alu_shamt_d   = alu_shamt_q;
    alu_use_imm_d = alu_use_imm_q;
    imm32_d       = imm32_q;
    res_data_d    = res_data_q;
    res_rd_d      = res_rd_q;
    res_we_d      = res_we_q;
    branch_d      = branch_q;
    illegal_d     = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        res_rd_d  = dec_rd;
        res_we_d  = dec_we;
        illegal_d = !dec_legal;
        // ALU-facing registers only move for legal work so the ALU never sees an illegal op
        if (dec_legal) begin
          alu_control_d = dec_ctrl;
          alu_shamt_d   = dec_shamt;
          alu_use_imm_d = dec_use_imm;
          imm32_d       = dec_imm32;
          state_d       = S_EXEC;
        end else begin
          res_data_d = '0;
          branch_d   = 1'b0;
          state_d    = S_RESP;
        end
      end
      S_EXEC: begin
        res_data_d = bus.alu_out;
        branch_d   = dec_is_branch && branch_eval(bus.alu_flag, dec_br_sel);
        state_d    = S_RESP;
      end
      S_RESP: begin
        if (resp_hs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      alu_control_q <= '0;
      alu_shamt_q   <= '0;
      alu_use_imm_q <= 1'b0;
      imm32_q       <= '0;
      res_data_q    <= '0;
      res_rd_q      <= '0;
      res_we_q      <= 1'b0;
      branch_q      <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      alu_control_q <= alu_control_d;
      alu_shamt_q   <= alu_shamt_d;
      alu_use_imm_q <= alu_use_imm_d;
      imm32_q       <= imm32_d;
      res_data_q    <= res_data_d;
      res_rd_q      <= res_rd_d;
      res_we_q      <= res_we_d;
      branch_q      <= branch_d;
      illegal_q     <= illegal_d;
    end
  end

  assign bus.instr_ready  = (state_q == S_IDLE);
  assign bus.res_valid    = (state_q == S_RESP);
  assign bus.alu_control  = alu_control_q;
  assign bus.alu_shamt    = alu_shamt_q;
  assign bus.alu_use_imm  = alu_use_imm_q;
  assign bus.imm32        = imm32_q;
  assign bus.res_data     = res_data_q;
  assign bus.res_rd       = res_rd_q;
  assign bus.res_we       = res_we_q;
  assign bus.branch_taken = branch_q;
  assign bus.illegal      = illegal_q;

`ifdef ALU_PERF_CNT_EN
  logic [31:0] retired_cnt_q, retired_cnt_d;

  always_comb begin
    retired_cnt_d = retired_cnt_q;
    if (resp_hs) retired_cnt_d = retired_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_cnt_q <= '0;
    else        retired_cnt_q <= retired_cnt_d;
  end

  assign retired_cnt = retired_cnt_q;
`endif
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Randomized bench for alu_issue_ctrl against an instruction-level reference model.
module tb_alu_issue_ctrl;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  logic [31:0] exp_cnt;
  logic [3:0]  prev_ctrl;
  logic        prev_use;

  alu_issue_ctrl_if #(.DATA_W(32), .CTRL_W(4)) bus ();

`ifdef ALU_PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  alu_issue_ctrl #(.DATA_W(32), .CTRL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef ALU_PERF_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_cnt(input string tag);
`ifdef ALU_PERF_CNT_EN
    chk(tag, retired_cnt, exp_cnt);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  function automatic logic [31:0] mk_r(input int op, input int rt, input int rd, input int sh, input int fn);
    return (op << 26) | (5'd7 << 21) | (rt << 16) | (rd << 11) | (sh << 6) | fn;
  endfunction

  function automatic logic [31:0] mk_i(input int op, input int rt, input logic [15:0] imm);
    return (op << 26) | (5'd3 << 21) | (rt << 16) | imm;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one instruction from IDLE and follow it to its response handshake.
  task automatic issue(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f, input int hold);
    int          op, rt, rd, sh, fn, sel;
    logic        legal, exp_br;
    logic [3:0]  exp_ctrl;
    logic [31:0] exp_imm, junk;
    op  = int'(w >> 26);
    rt  = int'((w >> 16) & 32'h1F);
    rd  = int'((w >> 11) & 32'h1F);
    sh  = int'((w >> 6) & 32'h1F);
    fn  = int'(w & 32'hF);
    sel = rt % 4;
    legal    = (op <= 2);
    exp_ctrl = (op == 0) ? 4'(fn) : 4'd0;
    exp_imm  = (w[15] == 1'b1) ? (32'hFFFF0000 | (w & 32'hFFFF)) : (w & 32'hFFFF);
    exp_br   = (op == 2) && (sel < 3) && (((f >> sel) & 3'd1) == 3'd1);

    chk("idle_rdy", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    bus.res_ready   = 1'b0;
    next_cycle();
    bus.instr_valid = 1'b0;
    junk            = $urandom;
    bus.instr       = junk;
    bus.alu_out     = ~a;
    bus.alu_flag    = ~f;
    chk("dec_vld", bus.res_valid, 0);
    chk("dec_rdy", bus.instr_ready, 0);
    chk("dec_ctrl_hold", bus.alu_control, prev_ctrl);
    chk("dec_imm_hold", bus.alu_use_imm, prev_use);
    if (legal) begin
      next_cycle();
      chk("exec_vld", bus.res_valid, 0);
      chk("exec_ctrl", bus.alu_control, exp_ctrl);
      chk("exec_use_imm", bus.alu_use_imm, (op == 1));
      if (op == 0) chk("exec_shamt", bus.alu_shamt, sh);
      if (op == 1) chk("exec_imm32", bus.imm32, exp_imm);
      bus.alu_out  = a;
      bus.alu_flag = f;
      prev_ctrl    = exp_ctrl;
      prev_use     = (op == 1);
    end
    next_cycle();
    for (int i = 0; i <= hold; i++) begin
      bus.alu_out  = ~a ^ 32'(i);
      bus.alu_flag = ~f;
      chk("resp_vld", bus.res_valid, 1);
      chk("resp_rdy", bus.instr_ready, 0);
      chk("resp_we", bus.res_we, (op <= 1));
      chk("resp_illegal", bus.illegal, !legal);
      chk("resp_branch", bus.branch_taken, exp_br);
      if (legal) chk("resp_data", bus.res_data, a);
      if (op == 0) chk("resp_rd_r", bus.res_rd, rd);
      if (op == 1) chk("resp_rd_i", bus.res_rd, rt);
      chk("resp_ctrl_hold", bus.alu_control, prev_ctrl);
      chk_cnt("resp_cnt");
      if (i < hold) next_cycle();
    end
    bus.res_ready = 1'b1;
    next_cycle();
    bus.res_ready = 1'b0;
    exp_cnt = exp_cnt + 32'd1;
    chk("post_vld", bus.res_valid, 0);
    chk("post_rdy", bus.instr_ready, 1);
    chk_cnt("post_cnt");
  endtask

  initial begin
    logic [31:0] w, a, r;
    int          op;
    n_chk = 0;
    n_err = 0;
    exp_cnt = 0;
    prev_ctrl = 0;
    prev_use = 0;
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.res_ready = 1'b0;
    bus.alu_out = '0;
    bus.alu_flag = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", bus.res_valid, 0);
    chk("rst_ctrl", bus.alu_control, 0);
    chk("rst_imm32", bus.imm32, 0);
    chk("rst_data", bus.res_data, 0);
    chk("rst_we", bus.res_we, 0);
    chk("rst_illegal", bus.illegal, 0);
    chk_cnt("rst_cnt");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_rdy", bus.instr_ready, 1);

    // res_ready with nothing pending must not retire anything
    bus.res_ready = 1'b1;
    repeat (2) next_cycle();
    bus.res_ready = 1'b0;
    chk("idle_ready_vld", bus.res_valid, 0);
    chk_cnt("idle_ready_cnt");

    issue(mk_r(0, 9, 12, 3, 5), 32'h8, 3'b101, 0);
    issue(mk_i(1, 17, 16'hFFFE), 32'h1234, 3'b000, 1);
    issue(mk_i(2, 1, 16'h0040), 32'h0, 3'b010, 0);
    issue(mk_i(2, 3, 16'h0040), 32'h0, 3'b111, 0);
    issue(mk_i(6'h3F, 4, 16'h5555), 32'hDEAD, 3'b111, 0);
    issue(mk_r(0, 2, 31, 17, 7), 32'hCAFEF00D, 3'b001, 5);

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 3);
      if (op == 3) op = $urandom_range(3, 63);
      r = $urandom;
      w = (32'(op) << 26) | (r & 32'h03FFFFFF);
      a = $urandom;
      issue(w, a, 3'($urandom_range(0, 7)), $urandom_range(0, 3));
    end

    // Reset while an instruction sits in EXEC
    bus.instr_valid = 1'b1;
    bus.instr = mk_r(0, 1, 2, 4, 6);
    next_cycle();
    bus.instr_valid = 1'b0;
    next_cycle();
    bus.res_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    prev_ctrl = 0;
    prev_use = 0;
    chk("mid_rst_vld", bus.res_valid, 0);
    chk("mid_rst_ctrl", bus.alu_control, 0);
    chk("mid_rst_we", bus.res_we, 0);
    chk("mid_rst_data", bus.res_data, 0);
    chk_cnt("mid_rst_cnt");
    @(negedge clk);
    rst_n = 1'b1;
    bus.res_ready = 1'b0;
    next_cycle();
    chk("mid_rel_rdy", bus.instr_ready, 1);
    chk("mid_rel_vld", bus.res_valid, 0);
    chk_cnt("mid_rel_cnt");
    issue(mk_i(1, 5, 16'h0001), 32'h77, 3'b000, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of operands/results.
REQ-002 SHALL have parameter CTRL_W, default 4, width of ALU control code.
REQ-003 SHALL have ports: clk  in  1  single clock, rising edge; rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports: instr_valid  in  1  instruction offered; instr_ready  out  1  controller can accept; instr  in  32  instruction word.
REQ-005 SHALL have ports: alu_control  out  CTRL_W  code to ALU; alu_shamt  out  5  shift amount; alu_use_imm  out  1  select imm32 as in2; imm32  out  DATA_W  sign-extended immediate.
REQ-006 SHALL have ports: alu_out  in  DATA_W  ALU result; alu_flag  in  3  {carry, rs<0, rs==0}.
REQ-007 SHALL have ports: res_valid  out  1; res_ready  in  1; res_data  out  DATA_W; res_rd  out  5  destination; res_we  out  1  writeback enable; branch_taken  out  1; illegal  out  1.
REQ-008 SHALL have, under ALU_PERF_CNT_EN only, port retired_cnt  out  32  count of completed instructions.

Function
REQ-009 Fields SHALL be: opcode instr[31:26], rs [25:21], rt [20:16], rd [15:11], shamt [10:6], funct [3:0], imm16 [15:0].
REQ-010 opcode 6'h00 (R-type) SHALL drive alu_control=funct, alu_shamt=shamt, alu_use_imm=0, res_we=1, res_rd=rd.
REQ-011 opcode 6'h01 (ADDI) SHALL drive alu_control=4'b0000, alu_use_imm=1, imm32=sign-extend(imm16), res_we=1, res_rd=rt.
REQ-012 opcode 6'h02 (BRANCH) SHALL drive alu_control=4'b0000, alu_use_imm=0, res_we=0; branch_taken=alu_flag[rt[1:0]] for rt[1:0] in {0,1,2}, 0 for rt[1:0]=3.
REQ-013 Any other opcode SHALL be illegal: illegal=1, res_we=0, branch_taken=0, ALU not sampled.
REQ-014 FSM states SHALL be IDLE, DECODE, EXEC, RESP.
REQ-015 IDLE: instr_ready=1; instr_valid&instr_ready SHALL latch instr and go DECODE.
REQ-016 DECODE: registers alu_control/alu_shamt/alu_use_imm/imm32 from latched instr; next state EXEC, or RESP directly if illegal.
REQ-017 EXEC: ALU outputs held stable one full cycle; alu_out and alu_flag SHALL be captured at end of EXEC into res_data/branch_taken; next RESP.
REQ-018 RESP: res_valid=1; res_data/res_rd/res_we/branch_taken/illegal SHALL stay stable until res_ready; on res_valid&res_ready go IDLE.
REQ-019 Latency instr accept to res_valid SHALL be 3 cycles legal, 2 cycles illegal; throughput one instruction per 4 cycles with res_ready=1.
REQ-020 instr_ready SHALL be 0 in all states except IDLE; instr changes outside IDLE SHALL be ignored.
REQ-021 alu_control/alu_shamt/alu_use_imm/imm32 SHALL hold last value outside EXEC (no glitch to ALU).
REQ-022 res_valid SHALL never deassert without handshake; res_ready while not res_valid SHALL have no effect.
REQ-023 Under ALU_PERF_CNT_EN, retired_cnt SHALL increment by 1 on each RESP handshake (illegal included), wrapping 32'hFFFFFFFF->0.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, instr_ready=1 after release, res_valid=0, all other outputs 0, retired_cnt=0.
REQ-025 Reset mid-operation SHALL drop the in-flight instruction without any result handshake.

Configuration
REQ-026 Macro ALU_PERF_CNT_EN defined: retired_cnt port and counter present; undefined: port and counter absent, all else identical.

Structure
REQ-027 Shared package SHALL hold opcode constants (OP_RTYPE, OP_ADDI, OP_BRANCH), ALU control codes (ADD, COMP, DIFF, AND, XOR, SLL, SRL, SRA, variable-shift bit 3), flag bit indices and FSM state enum.
REQ-028 One sub-module alu_instr_decode (combinational field decode/legality) SHALL be instantiated; FSM and registers in top.

Verification
REQ-029 R-type funct=4'b0101, shamt=3 -> DECODE then EXEC with alu_control=0101, alu_shamt=3; alu_out=32'h8 captured, res_rd=rd, res_we=1, res_valid 3 cycles after accept.
REQ-030 ADDI imm16=16'hFFFE -> imm32=32'hFFFFFFFE, alu_use_imm=1, res_rd=rt.
REQ-031 BRANCH rt=1 with alu_flag=3'b010 -> branch_taken=1, res_we=0; rt=3 -> branch_taken=0.
REQ-032 opcode 6'h3F -> illegal=1, res_valid 2 cycles after accept, no EXEC state.
REQ-033 res_ready held 0 for 5 cycles -> res_valid and all result outputs stable, instr_ready=0; retired_cnt +1 only after handshake.
REQ-034 rst_n asserted during EXEC -> immediate IDLE, res_valid=0, retired_cnt=0.
